// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw clock/data pair,
// frames 11-bit PS/2 words and turns scancode sequences into ps2_key events.
module ps2_key_decoder #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 8590
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key_o,
    output logic        frame_err_o
);

    localparam int unsigned FW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic          r_clk_flt, r_dat_flt, r_clk_prev;
    logic [FW-1:0] r_clk_cnt, r_dat_cnt;
    logic [TW-1:0] r_tmo;
    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic          r_ext, r_rel;
    logic [10:0]   r_key;
    logic          r_err;
    logic          w_fall;
    logic          w_ignore;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_data_i;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Filter: a level is accepted after FILTER consecutive samples that differ
    // from the current filtered level; any agreeing sample restarts the count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_clk_flt  <= 1'b1;
            r_dat_flt  <= 1'b1;
            r_clk_prev <= 1'b1;
            r_clk_cnt  <= '0;
            r_dat_cnt  <= '0;
        end else begin
            r_clk_prev <= r_clk_flt;
            if (r_clk_sync == r_clk_flt) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == FW'(FILTER - 1)) begin
                r_clk_flt <= r_clk_sync;
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            if (r_dat_sync == r_dat_flt) begin
                r_dat_cnt <= '0;
            end else if (r_dat_cnt == FW'(FILTER - 1)) begin
                r_dat_flt <= r_dat_sync;
                r_dat_cnt <= '0;
            end else begin
                r_dat_cnt <= r_dat_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_flt;

    always_comb begin
        w_ignore = 1'b0;
        case (r_shift)
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_ignore = 1'b1;
            default:                                         w_ignore = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par_ok <= 1'b0;
            r_tmo    <= '0;
            r_ext    <= 1'b0;
            r_rel    <= 1'b0;
            r_key    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_fall) begin
                r_tmo <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_flt) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end else begin
                            r_err <= 1'b1;
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {r_dat_flt, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, r_dat_flt};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (r_dat_flt && r_par_ok) begin
                            if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_rel <= 1'b1;
                            end else begin
                                if (!w_ignore) r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
                                r_ext <= 1'b0;
                                r_rel <= 1'b0;
                            end
                        end else begin
                            r_err <= 1'b1;
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                // Abort after TIMEOUT consecutive cycles without a strobe.
                if (r_tmo == TW'(TIMEOUT - 1)) begin
                    r_state <= S_IDLE;
                    r_tmo   <= '0;
                    r_err   <= 1'b1;
                    r_ext   <= 1'b0;
                    r_rel   <= 1'b0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign ps2_key_o   = r_key;
    assign frame_err_o = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// randomized PS/2 frames, compared against a byte-stream event model.
module tb_ps2_key_decoder;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    logic [10:0] exp_key = '0;
    logic        m_ext = 1'b0;
    logic        m_rel = 1'b0;
    int          half = 20;

    ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .ps2_key_o  (ps2_key),
        .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a pulse longer than one cycle is over-counted.
    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(half);
            ps2_clk = 1'b1;
            wait_cyc(half - 5);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({stop, par, b, 1'b0}, 11);
        wait_cyc(15);
    endtask

    function automatic logic is_filtered(input logic [7:0] b);
        logic [7:0] codes [7];
        codes = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        for (int i = 0; i < 7; i++) if (codes[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_discard();
        exp_err++;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            model_discard();
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            if (!is_filtered(b)) exp_key = {~exp_key[10], ~m_rel, m_ext, b};
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (ps2_key === exp_key) else begin
            miscompares++;
            $error("FAIL %s key: got %h want %h", tag, ps2_key, exp_key);
        end
        vectors++;
        assert (err_seen === exp_err) else begin
            miscompares++;
            $error("FAIL %s err_count: got %0d want %0d", tag, err_seen, exp_err);
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par, input logic stop, input string tag);
        send_frame(b, bad_par, stop);
        model_byte(b, !bad_par && stop);
        check(tag);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] codes [7];
        int r;
        codes = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check("reset");
        rst_n = 1'b1;
        wait_cyc(20);

        frame(8'h1C, 1'b0, 1'b1, "make_1C");
        vectors++;
        assert (ps2_key === 11'h61C) else begin
            miscompares++;
            $error("FAIL make_abs key: got %h want %h", ps2_key, 11'h61C);
        end

        frame(8'hE0, 1'b0, 1'b1, "ext_E0");
        frame(8'hF0, 1'b0, 1'b1, "rel_F0");
        frame(8'h75, 1'b0, 1'b1, "break_75");
        vectors++;
        assert (ps2_key === 11'h175) else begin
            miscompares++;
            $error("FAIL break_abs key: got %h want %h", ps2_key, 11'h175);
        end

        frame(8'h1C, 1'b1, 1'b1, "parity_err");
        frame(8'h1C, 1'b0, 1'b1, "after_parity");

        send_bits({1'b1, ~(^8'h29), 8'h29, 1'b0}, 5);
        wait_cyc(TIMEOUT + 10);
        model_discard();
        check("timeout");
        frame(8'h29, 1'b0, 1'b1, "after_timeout");

        frame(8'hF0, 1'b0, 1'b1, "rel_then_abort");
        frame(8'h44, 1'b0, 1'b0, "stop_err");
        frame(8'h1C, 1'b0, 1'b1, "prefix_cleared");
        frame(8'hFA, 1'b0, 1'b1, "filtered_FA");
        frame(8'hAA, 1'b0, 1'b1, "filtered_AA");

        ps2_clk = 1'b0;
        wait_cyc(FILTER - 1);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check("clk_glitch");

        send_bits({1'b1, ~(^8'h5A), 8'h5A, 1'b0}, 5);
        ps2_data = 1'b1;
        wait_cyc(3);
        rst_n = 1'b0;
        exp_key = '0;
        m_ext = 1'b0;
        m_rel = 1'b0;
        wait_cyc(5);
        check("mid_reset");
        rst_n = 1'b1;
        wait_cyc(40);
        check("after_reset_idle");
        frame(8'h5A, 1'b0, 1'b1, "after_reset_frame");

        for (int n = 0; n < 40; n++) begin
            half = $urandom_range(15, 28);
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            case (r)
                0, 1:    frame(8'hE0, 1'b0, 1'b1, "rnd_E0");
                2, 3:    frame(8'hF0, 1'b0, 1'b1, "rnd_F0");
                4:       frame(codes[$urandom_range(0, 6)], 1'b0, 1'b1, "rnd_filt");
                5:       frame(b, 1'b1, 1'b1, "rnd_parity");
                6:       frame(b, 1'b0, 1'b0, "rnd_stop");
                default: frame(b, 1'b0, 1'b1, "rnd_byte");
            endcase
            wait_cyc($urandom_range(0, 30));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Decodes the raw PS/2 keyboard wire pair (clock/data from the physical connector) into the 11-bit `ps2_key` event word that the Sord M5 core consumes (`[10]` toggle strobe, `[9]` pressed, `[8]` extended, `[7:0]` scancode). It is the producing end of that interface. Board variants without an IO controller use it to feed `sordM5` directly. It sits in the guest top between the keyboard pins and `sordM5.ps2_key_i`, clocked by `clk_sys`.

## Interface
Parameters:
- `FILTER`, 8: consecutive identical synchronized samples needed before a line level is accepted.
- `TIMEOUT`, 8590: cycles without a filtered clock falling edge that abort a partial frame (≈200 µs at 42.95 MHz).

Ports:
- `clk_i` in 1: system clock (`clk_sys`). One clock; all state is on its rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `ps2_clk_i` in 1: raw PS/2 clock, asynchronous to `clk_i`.
- `ps2_data_i` in 1: raw PS/2 data, asynchronous to `clk_i`.
- `ps2_key_o` out 11: key event word. `[10]` toggles once per event, `[9]` is 1 for make and 0 for break, `[8]` is the E0 flag, `[7:0]` is the scancode.
- `frame_err_o` out 1: one-cycle pulse on a frame that is discarded (bad start, parity, stop, or timeout).

## Operation
- Input conditioning: each line passes a 2-FF synchronizer, then a filter.
  - The filtered level changes only after `FILTER` consecutive equal synchronized samples. A counter restarts on any mismatch.
  - Filtered levels reset to 1.
- A falling-edge strobe is generated from the filtered clock (previous=1, current=0). Data is sampled from filtered data in the same cycle.
- Frame FSM:
  - IDLE: on strobe with data=0, go to DATA and clear the bit counter. On strobe with data=1, pulse `frame_err_o` and stay in IDLE.
  - DATA: 8 strobes, shifted in LSB first; then go to PARITY.
  - PARITY: sample the bit. Odd parity over the 8 data bits plus the parity bit is required. Go to STOP.
  - STOP: sample the bit. If stop=1 and parity was good, the frame is accepted and the byte goes to the event stage. Otherwise pulse `frame_err_o`. Return to IDLE in either case.
- Timeout: the counter clears on every strobe and counts while the FSM is not IDLE. At `TIMEOUT` it forces IDLE, pulses `frame_err_o`, and clears the prefix flags.
- Event stage (accepted bytes only):
  - 0xE0: set `ext`. No output.
  - 0xF0: set `rel`. No output.
  - 0xE1, 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: no output; clear `ext` and `rel`.
  - Any other byte: load `ps2_key_o[7:0]`=byte, `[8]`=`ext`, `[9]`=~`rel`, invert `[10]`, then clear `ext` and `rel`.
- Any discarded frame clears `ext` and `rel`. A half-received prefix sequence never produces a wrong-polarity event.
- `ps2_key_o[9:0]` holds its value between events. Consumers detect new events only by a change of `[10]`.

## Timing
- Reset values: `ps2_key_o`=0, `frame_err_o`=0, FSM=IDLE, `ext`=`rel`=0, filtered levels=1, all counters=0.
- Reset may assert mid-frame. The partial frame is dropped, and nothing is output after release until a fresh start bit arrives.
- Latency from a raw clock falling edge to the strobe: 2 (sync) + `FILTER` + 1 cycles.
- `ps2_key_o` and `frame_err_o` update on the clock edge following the STOP-bit strobe cycle. `frame_err_o` is high for exactly one cycle.
- Back-to-back frames: the FSM is in IDLE on the cycle after STOP, so no frame gap is required beyond the PS/2 idle bit.
- Simultaneous timeout and strobe in the same cycle: the strobe wins and the timeout counter clears.
- Glitches shorter than `FILTER` cycles on either line have no effect.

## Test plan
- Make key: frame 0x1C (A), parity 0, from reset -> `ps2_key_o`=0x61C ([10]=1, [9]=1, [8]=0), `frame_err_o` stays 0.
- Break with extended prefix: frames E0, F0, 75 -> one event, `ps2_key_o`[9:0]=0x175, [10] toggled; no output after the E0 or F0 frames.
- Parity error: frame 0x1C with parity 1 -> `frame_err_o` pulses once, `ps2_key_o` unchanged. A following valid 0x1C produces a make event.
- Timeout: 5 clock edges, then silence for `TIMEOUT`+10 cycles -> `frame_err_o` pulse, FSM returns to IDLE. A subsequent full frame 0x29 decodes as 0x229 with [10] toggled.
- Filtered codes and prefix clear: send F0, then an aborted frame, then 0x1C -> output is a make event (`[9]`=1). Sending 0xFA or 0xAA produces no toggle.
- Glitch and reset: a `FILTER`-1 cycle low pulse on `ps2_clk_i` produces no strobe. Asserting `reset_n_i` during bit 4 returns `ps2_key_o` to 0, and the next complete frame decodes correctly.
